// File: rtl/axis_upsizer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : axis_upsizer_pkg
// Brief    : Shared types, limits and helpers for the upsizer input arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package axis_upsizer_pkg;

  localparam int MAX_SRC = 16;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  // Width of a source index; never narrower than one bit.
  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/axis_upsizer_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Brief    : Combinational round-robin selector. Returns the first set request
//            at or after ptr, wrapping modulo NUM_SRC.
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick #(
  parameter int NUM_SRC = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic               any_req,
  output logic [ID_W-1:0]    idx
);

  logic [2*NUM_SRC-1:0] req_dbl;
  logic [NUM_SRC-1:0]   req_rot;
  logic [ID_W-1:0]      offset;
  logic [ID_W:0]        sum;

  // Rotate so ptr lands on bit 0, priority-encode lowest set bit, rotate back.
  always_comb begin
    req_dbl = {req, req} >> ptr;
    req_rot = req_dbl[NUM_SRC-1:0];
    offset  = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req_rot[i]) begin
        offset = ID_W'(i);
      end
    end
    sum = {1'b0, ptr} + {1'b0, offset};
    if (sum >= (ID_W + 1)'(NUM_SRC)) begin
      sum = sum - (ID_W + 1)'(NUM_SRC);
    end
    idx     = sum[ID_W-1:0];
    any_req = |req;
  end

endmodule
`default_nettype wire

// File: rtl/axis_upsizer_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : axis_upsizer_arbiter
// Brief    : Packet-level round-robin arbiter sharing one upsizer input among
//            NUM_SRC AXI-stream sources. Grant is held for a whole packet or
//            until MAX_BEATS beats, whichever comes first.
// Revision : 1.0 - initial release
// ============================================================================
module axis_upsizer_arbiter
  import axis_upsizer_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int NUM_SRC   = 4,
  parameter int MAX_BEATS = 64,
  parameter int ID_W      = id_width(NUM_SRC)
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic [NUM_SRC-1:0]       s_axis_tvalid,
  output logic [NUM_SRC-1:0]       s_axis_tready,
  input  logic [NUM_SRC*WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_SRC-1:0]       s_axis_tlast,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic [WIDTH-1:0]         m_axis_tdata,
  output logic                     m_axis_tlast,
  output logic [ID_W-1:0]          m_axis_tid,
  output logic                     busy,
  output logic                     forced_cut
);

  localparam int                CNT_W    = $clog2(MAX_BEATS + 1);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(MAX_BEATS - 1);
  localparam logic [ID_W-1:0]   LAST_ID  = ID_W'(NUM_SRC - 1);

  if (NUM_SRC < 2 || NUM_SRC > MAX_SRC) begin : g_bad_num_src
    $error("axis_upsizer_arbiter: NUM_SRC out of range");
  end

  arb_state_t       state_q, state_d;
  logic [ID_W-1:0]  grant_q, grant_d;
  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;

  logic             pick_any;
  logic [ID_W-1:0]  pick_idx;
  logic             src_last;
  logic             beat_fire;

  rr_pick #(
    .NUM_SRC (NUM_SRC),
    .ID_W    (ID_W)
  ) u_rr_pick (
    .req     (s_axis_tvalid),
    .ptr     (rr_ptr_q),
    .any_req (pick_any),
    .idx     (pick_idx)
  );

  // State, grant, pointer and beat counter registers; reset drops any grant.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  // Arbitration in IDLE; in BUSY mux the granted source and detect release.
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    rr_ptr_d      = rr_ptr_q;
    beat_cnt_d    = beat_cnt_q;
    s_axis_tready = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = '0;
    m_axis_tlast  = 1'b0;
    m_axis_tid    = '0;
    forced_cut    = 1'b0;
    src_last      = 1'b0;
    beat_fire     = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          grant_d    = pick_idx;
          beat_cnt_d = '0;
          state_d    = BUSY;
        end
      end
      BUSY: begin
        src_last               = s_axis_tlast[grant_q];
        m_axis_tvalid          = s_axis_tvalid[grant_q];
        m_axis_tdata           = s_axis_tdata[int'(grant_q) * WIDTH +: WIDTH];
        m_axis_tid             = grant_q;
        s_axis_tready[grant_q] = m_axis_tready;
        m_axis_tlast           = src_last | (beat_cnt_q == LAST_CNT);
        beat_fire              = m_axis_tvalid & m_axis_tready;
        if (beat_fire) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
          if (m_axis_tlast) begin
            // The source that just finished gets lowest priority next time.
            state_d    = IDLE;
            rr_ptr_d   = (grant_q == LAST_ID) ? '0 : grant_q + 1'b1;
            forced_cut = ~src_last;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q == BUSY);

endmodule
`default_nettype wire

// File: tb/tb_axis_upsizer_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_axis_upsizer_arbiter
// Brief    : Self-checking bench for axis_upsizer_arbiter with per-source
//            packet queues and a transaction-level arbitration model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axis_upsizer_arbiter;

  localparam int WIDTH     = 32;
  localparam int NUM_SRC   = 4;
  localparam int MAX_BEATS = 64;
  localparam int ID_W      = 2;

  logic                     aclk = 1'b0;
  logic                     aresetn = 1'b0;
  logic [NUM_SRC-1:0]       s_axis_tvalid;
  logic [NUM_SRC-1:0]       s_axis_tready;
  logic [NUM_SRC*WIDTH-1:0] s_axis_tdata;
  logic [NUM_SRC-1:0]       s_axis_tlast;
  logic                     m_axis_tvalid;
  logic                     m_axis_tready;
  logic [WIDTH-1:0]         m_axis_tdata;
  logic                     m_axis_tlast;
  logic [ID_W-1:0]          m_axis_tid;
  logic                     busy;
  logic                     forced_cut;

  axis_upsizer_arbiter #(
    .WIDTH     (WIDTH),
    .NUM_SRC   (NUM_SRC),
    .MAX_BEATS (MAX_BEATS),
    .ID_W      (ID_W)
  ) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tlast  (s_axis_tlast),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tid    (m_axis_tid),
    .busy          (busy),
    .forced_cut    (forced_cut)
  );

  initial forever #5 aclk = ~aclk;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             last;
  } beat_t;

  typedef struct packed {
    logic [ID_W-1:0]  tid;
    logic [WIDTH-1:0] data;
    logic             last;
    logic             forced;
  } obs_t;

  beat_t drv_q [NUM_SRC][$];
  beat_t exp_q [NUM_SRC][$];
  logic  rdy_q [$];
  int    vld_pct = 100;
  int    rdy_pct = 100;
  logic [NUM_SRC-1:0] vld_held = '0;
  logic [NUM_SRC-1:0] hs = '0;

  obs_t  beat_log [$];
  int    grant_log [$];
  logic  busy_trace [$];
  int    model_err = 0;
  string model_msg = "";
  int    loser_rdy = 0;
  logic  prev_busy = 1'b0;

  // Reference model: who should hold the grant, and where the pointer sits.
  logic  md_busy = 1'b0;
  int    md_tid = 0;
  int    md_ptr = 0;
  int    md_cnt = 0;
  logic  md_found;
  beat_t md_eb;
  logic  md_last, md_forced;
  logic [NUM_SRC-1:0] md_rdy;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic md_note(input string m);
    if (model_err == 0) model_msg = m;
    model_err++;
  endtask

  // Source/sink driver at negedge, observation and model step 4 ns later.
  initial begin
    s_axis_tvalid = '0;
    s_axis_tdata  = '0;
    s_axis_tlast  = '0;
    m_axis_tready = 1'b0;
    forever begin
      @(negedge aclk);
      for (int s = 0; s < NUM_SRC; s++) begin
        if (hs[s] && drv_q[s].size() > 0) begin
          void'(drv_q[s].pop_front());
          vld_held[s] = 1'b0;
        end
        if (drv_q[s].size() == 0) vld_held[s] = 1'b0;
        else if (!vld_held[s] && $urandom_range(99) < vld_pct) vld_held[s] = 1'b1;
        s_axis_tvalid[s] = vld_held[s];
        if (drv_q[s].size() > 0) begin
          s_axis_tdata[s*WIDTH +: WIDTH] = drv_q[s][0].data;
          s_axis_tlast[s]                = drv_q[s][0].last;
        end else begin
          s_axis_tdata[s*WIDTH +: WIDTH] = '0;
          s_axis_tlast[s]                = 1'b0;
        end
      end
      if (rdy_q.size() > 0) m_axis_tready = rdy_q.pop_front();
      else m_axis_tready = ($urandom_range(99) < rdy_pct);

      #4;
      for (int s = 0; s < NUM_SRC; s++) hs[s] = s_axis_tvalid[s] & s_axis_tready[s];
      busy_trace.push_back(busy);
      if (busy && !prev_busy) grant_log.push_back(int'(m_axis_tid));
      prev_busy = busy;
      if (m_axis_tvalid && m_axis_tready)
        beat_log.push_back('{m_axis_tid, m_axis_tdata, m_axis_tlast, forced_cut});
      if (busy) begin
        if ((s_axis_tready & ~(NUM_SRC'(1) << m_axis_tid)) != '0) loser_rdy++;
      end else if (s_axis_tready != '0) loser_rdy++;

      if (!aresetn) begin
        if ({m_axis_tvalid, s_axis_tready, busy, m_axis_tid, forced_cut, m_axis_tlast} !== '0
            || m_axis_tdata !== '0)
          md_note("outputs not zero in reset");
        md_busy = 1'b0;
        md_ptr  = 0;
        md_cnt  = 0;
      end else if (md_busy) begin
        md_rdy = m_axis_tready ? (NUM_SRC'(1) << md_tid) : '0;
        if (busy !== 1'b1 || int'(m_axis_tid) != md_tid)
          md_note($sformatf("busy/tid got %0b/%0d want 1/%0d", busy, m_axis_tid, md_tid));
        if (m_axis_tvalid !== s_axis_tvalid[md_tid]) md_note("m_axis_tvalid not following granted source");
        if (s_axis_tready !== md_rdy)
          md_note($sformatf("s_axis_tready got %b want %b", s_axis_tready, md_rdy));
        if (s_axis_tvalid[md_tid] && m_axis_tready) begin
          if (exp_q[md_tid].size() == 0) begin
            md_note($sformatf("unexpected beat from source %0d", md_tid));
          end else begin
            md_eb     = exp_q[md_tid].pop_front();
            md_last   = md_eb.last || (md_cnt == MAX_BEATS - 1);
            md_forced = !md_eb.last && (md_cnt == MAX_BEATS - 1);
            if (m_axis_tdata !== md_eb.data || m_axis_tlast !== md_last || forced_cut !== md_forced)
              md_note($sformatf("beat src%0d data %h/%h last %0b/%0b cut %0b/%0b", md_tid,
                      m_axis_tdata, md_eb.data, m_axis_tlast, md_last, forced_cut, md_forced));
            md_cnt++;
            if (md_last) begin
              md_busy = 1'b0;
              md_ptr  = (md_tid + 1) % NUM_SRC;
            end
          end
        end else if (forced_cut !== 1'b0) md_note("forced_cut without a beat");
      end else begin
        if (busy !== 1'b0 || m_axis_tvalid !== 1'b0 || s_axis_tready !== '0 || forced_cut !== 1'b0)
          md_note("activity during an idle cycle");
        md_found = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
          if (!md_found && s_axis_tvalid[(md_ptr + k) % NUM_SRC]) begin
            md_tid   = (md_ptr + k) % NUM_SRC;
            md_found = 1'b1;
          end
        end
        if (md_found) begin
          md_busy = 1'b1;
          md_cnt  = 0;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running at %0t, required finish earlier", $time);
    $fatal(1);
  end

  task automatic load_pkt(input int s, input int n, input logic [WIDTH-1:0] base, input bit with_last);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.data = base + WIDTH'(i);
      b.last = with_last && (i == n - 1);
      drv_q[s].push_back(b);
      exp_q[s].push_back(b);
    end
  endtask

  task automatic clear_logs();
    beat_log.delete();
    grant_log.delete();
    busy_trace.delete();
    model_err = 0;
    model_msg = "";
    loser_rdy = 0;
  endtask

  task automatic wait_drain(input int budget, output bit ok);
    int quiet = 0;
    int pending;
    ok = 1'b0;
    for (int c = 0; c < budget && !ok; c++) begin
      @(posedge aclk); #1;
      pending = 0;
      for (int s = 0; s < NUM_SRC; s++) pending += drv_q[s].size() + exp_q[s].size();
      if (pending == 0 && !busy) quiet++;
      else quiet = 0;
      if (quiet >= 2) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    bit ok;
    clear_logs();
    vld_pct = 100;
    rdy_pct = 100;
    load_pkt(0, 3, 32'h0000_0100, 1'b1);
    load_pkt(1, 1, 32'h0000_1100, 1'b1);
    load_pkt(2, 1, 32'h0000_2100, 1'b1);
    load_pkt(3, 1, 32'h0000_3100, 1'b1);
    repeat (3) @(posedge aclk);
    #1;
    n_tests++;
    if ({m_axis_tvalid, s_axis_tready, busy, m_axis_tid, forced_cut, m_axis_tlast} !== '0) begin
      n_fail++;
      $display("FAIL reset_ctrl_outputs: got %b want 0", {m_axis_tvalid, s_axis_tready, busy, m_axis_tid, forced_cut, m_axis_tlast});
    end
    n_tests++;
    if (m_axis_tdata !== '0) begin
      n_fail++;
      $display("FAIL reset_tdata: got %h want 0", m_axis_tdata);
    end
    @(negedge aclk);
    aresetn = 1'b1;
    @(posedge aclk); #1;
    n_tests++;
    if (busy !== 1'b1 || m_axis_tid !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_first_grant: busy/tid got %0b/%0d want 1/0", busy, m_axis_tid);
    end
    wait_drain(200, ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL reset_drain: got timeout want drained"); end
    n_tests++;
    if (grant_log.size() != 4 || grant_log[0] != 0 || grant_log[1] != 1 || grant_log[2] != 2 || grant_log[3] != 3) begin
      n_fail++;
      $display("FAIL reset_grant_order: got %p want 0,1,2,3", grant_log);
    end
    n_tests++;
    if (beat_log.size() != 6 || beat_log[0].tid != 0 || beat_log[2].tid != 0 || beat_log[2].data != 32'h102
        || beat_log[2].last != 1'b1 || beat_log[1].last != 1'b0) begin
      n_fail++;
      $display("FAIL reset_src0_packet: got %0d beats want 6 with src0 3-beat packet first", beat_log.size());
    end
    n_tests++;
    if (model_err != 0) begin n_fail++; $display("FAIL reset_model: got %0d errors want 0 (%s)", model_err, model_msg); end
  endtask

  task automatic test_rr_two_sources();
    bit ok;
    int first = -1, last = -1, gaps = 0;
    clear_logs();
    load_pkt(1, 2, 32'h0000_0110, 1'b1);
    load_pkt(1, 2, 32'h0000_0120, 1'b1);
    load_pkt(3, 2, 32'h0000_0310, 1'b1);
    load_pkt(3, 2, 32'h0000_0320, 1'b1);
    wait_drain(200, ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL rr_drain: got timeout want drained"); end
    n_tests++;
    if (grant_log.size() != 4 || grant_log[0] != 1 || grant_log[1] != 3 || grant_log[2] != 1 || grant_log[3] != 3) begin
      n_fail++;
      $display("FAIL rr_grant_order: got %p want 1,3,1,3", grant_log);
    end
    for (int i = 0; i < busy_trace.size(); i++) if (busy_trace[i]) begin if (first < 0) first = i; last = i; end
    for (int i = (first < 0 ? 0 : first); i <= last; i++) if (!busy_trace[i]) gaps++;
    n_tests++;
    if (gaps != 3) begin n_fail++; $display("FAIL rr_bubbles: got %0d idle cycles want 3", gaps); end
    n_tests++;
    if (beat_log.size() != 8 || beat_log[2].data != 32'h310 || beat_log[5].data != 32'h121) begin
      n_fail++;
      $display("FAIL rr_data_order: got %0d beats want 8 in order 110,111,310,311,120,121,...", beat_log.size());
    end
    n_tests++;
    if (loser_rdy != 0 || model_err != 0) begin
      n_fail++;
      $display("FAIL rr_losers_model: got loser_ready=%0d model_err=%0d want 0/0 (%s)", loser_rdy, model_err, model_msg);
    end
  endtask

  task automatic test_forced_cut();
    bit ok;
    int cuts = 0, first = -1, last = -1, gaps = 0;
    clear_logs();
    load_pkt(2, 70, 32'h0000_2000, 1'b1);
    wait_drain(400, ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL cut_drain: got timeout want drained"); end
    for (int i = 0; i < beat_log.size(); i++) if (beat_log[i].forced) cuts++;
    n_tests++;
    if (cuts != 1) begin n_fail++; $display("FAIL cut_pulse_count: got %0d want 1", cuts); end
    n_tests++;
    if (beat_log.size() != 70 || beat_log[63].last != 1'b1 || beat_log[63].forced != 1'b1
        || beat_log[62].last != 1'b0 || beat_log[64].data != 32'h2040 || beat_log[69].last != 1'b1
        || beat_log[69].forced != 1'b0) begin
      n_fail++;
      $display("FAIL cut_beat64: got %0d beats want 70 with forced last on beat 64 only", beat_log.size());
    end
    n_tests++;
    if (grant_log.size() != 2 || grant_log[0] != 2 || grant_log[1] != 2) begin
      n_fail++;
      $display("FAIL cut_regrant: got %p want 2,2", grant_log);
    end
    for (int i = 0; i < busy_trace.size(); i++) if (busy_trace[i]) begin if (first < 0) first = i; last = i; end
    for (int i = (first < 0 ? 0 : first); i <= last; i++) if (!busy_trace[i]) gaps++;
    n_tests++;
    if (gaps != 1 || model_err != 0) begin
      n_fail++;
      $display("FAIL cut_bubble_model: got gaps=%0d model_err=%0d want 1/0 (%s)", gaps, model_err, model_msg);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    int busy_cycles = 0;
    logic pat [$] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    clear_logs();
    foreach (pat[i]) rdy_q.push_back(pat[i]);
    load_pkt(0, 4, 32'h0000_0A00, 1'b1);
    wait_drain(200, ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL bp_drain: got timeout want drained"); end
    for (int i = 0; i < busy_trace.size(); i++) if (busy_trace[i]) busy_cycles++;
    n_tests++;
    if (busy_cycles != 8) begin n_fail++; $display("FAIL bp_busy_cycles: got %0d want 8", busy_cycles); end
    n_tests++;
    if (beat_log.size() != 4 || beat_log[0].data != 32'hA00 || beat_log[1].data != 32'hA01
        || beat_log[2].data != 32'hA02 || beat_log[3].data != 32'hA03 || beat_log[3].tid != 0) begin
      n_fail++;
      $display("FAIL bp_data_order: got %0d beats want A00..A03 from src0", beat_log.size());
    end
    n_tests++;
    if (model_err != 0) begin n_fail++; $display("FAIL bp_model: got %0d errors want 0 (%s)", model_err, model_msg); end
  endtask

  task automatic test_reset_mid_packet();
    bit ok = 1'b0;
    clear_logs();
    load_pkt(0, 5, 32'h0000_0B00, 1'b1);
    for (int c = 0; c < 50 && !ok; c++) begin
      @(posedge aclk); #1;
      if (beat_log.size() >= 1) ok = 1'b1;
    end
    n_tests++;
    if (!ok || m_axis_tvalid !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_pre: got started=%0b tvalid=%0b want 1/1", ok, m_axis_tvalid);
    end
    #1 aresetn = 1'b0;
    #1;
    n_tests++;
    if (m_axis_tvalid !== 1'b0 || s_axis_tready !== '0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_drop: got tvalid=%0b tready=%b busy=%0b want 0/0000/0", m_axis_tvalid, s_axis_tready, busy);
    end
    for (int s = 0; s < NUM_SRC; s++) begin drv_q[s].delete(); exp_q[s].delete(); end
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    @(posedge aclk); #1;
    clear_logs();
    load_pkt(0, 1, 32'h0000_0C00, 1'b1);
    load_pkt(2, 1, 32'h0000_2C00, 1'b1);
    wait_drain(100, ok);
    n_tests++;
    if (!ok || grant_log.size() != 2 || grant_log[0] != 0 || grant_log[1] != 2) begin
      n_fail++;
      $display("FAIL midrst_ptr_cleared: got %p want 0,2", grant_log);
    end
  endtask

  task automatic test_chain_tid();
    bit ok;
    clear_logs();
    load_pkt(1, 4, 32'h0000_000A, 1'b1);
    wait_drain(100, ok);
    n_tests++;
    if (!ok || beat_log.size() != 4) begin n_fail++; $display("FAIL chain_beats: got %0d want 4", beat_log.size()); end
    n_tests++;
    if (beat_log.size() == 4 && (beat_log[0].tid != 1 || beat_log[1].tid != 1 || beat_log[2].tid != 1
        || beat_log[3].tid != 1 || beat_log[3].data != 32'hD || beat_log[3].last != 1'b1
        || beat_log[2].last != 1'b0 || beat_log[0].data != 32'hA)) begin
      n_fail++;
      $display("FAIL chain_tid_data: got tid0=%0d data3=%h want tid 1 and A,B,C,D", beat_log[0].tid, beat_log[3].data);
    end
  endtask

  task automatic test_random();
    bit ok;
    int total = 0, cuts = 0, n, big;
    clear_logs();
    vld_pct = 60;
    rdy_pct = 70;
    big = $urandom_range(NUM_SRC - 1);
    for (int s = 0; s < NUM_SRC; s++) begin
      for (int p = 0; p < 6; p++) begin
        n = $urandom_range(8, 1);
        load_pkt(s, n, WIDTH'($urandom), 1'b1);
        total += n;
      end
      if (s == big) begin
        load_pkt(s, 66, WIDTH'($urandom), 1'b1);
        total += 66;
      end
    end
    wait_drain(5000, ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL rand_drain: got timeout want drained"); end
    for (int i = 0; i < beat_log.size(); i++) if (beat_log[i].forced) cuts++;
    n_tests++;
    if (beat_log.size() != total || cuts != 1) begin
      n_fail++;
      $display("FAIL rand_counts: got beats=%0d cuts=%0d want %0d/1", beat_log.size(), cuts, total);
    end
    n_tests++;
    if (model_err != 0 || loser_rdy != 0) begin
      n_fail++;
      $display("FAIL rand_model: got model_err=%0d loser_ready=%0d want 0/0 (%s)", model_err, loser_rdy, model_msg);
    end
    vld_pct = 100;
    rdy_pct = 100;
  endtask

  initial begin
    test_reset();
    test_rr_two_sources();
    test_forced_cut();
    test_backpressure();
    test_reset_mid_packet();
    test_chain_tid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
